digit_entry_ctrl: RTL and testbench

- Button-driven time-entry controller that produces the digit-load interface (select, loadin, load, almin, tmrin) consumed by the clock, alarm and timer sections of digi_clk.
- The operator snapshots the current value, edits one BCD digit at a time with range checking, then commits.
- On commit the block replays each digit to the consumer on consecutive clk_out edges.
- Sits between the board push-buttons and the digi_clk load inputs.

---
 rtl/digi_clk_pkg.sv | 69 ++++++
 rtl/btn_edge.sv | 24 ++
 rtl/digit_entry_ctrl.sv | 120 ++++++++++++
 tb/tb_digit_entry_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digi_clk_pkg.sv
// rtl/digi_clk_pkg.sv - shared types, encodings and digit-range helpers for digi_clk entry logic
package digi_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EDIT,
        ST_COMMIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_CLK = 2'b00;
    localparam logic [1:0] MODE_ALM = 2'b01;
    localparam logic [1:0] MODE_TMR = 2'b10;

    localparam logic [2:0] IDX_S2 = 3'd0;
    localparam logic [2:0] IDX_S1 = 3'd1;
    localparam logic [2:0] IDX_M2 = 3'd2;
    localparam logic [2:0] IDX_M1 = 3'd3;
    localparam logic [2:0] IDX_H2 = 3'd4;
    localparam logic [2:0] IDX_H1 = 3'd5;

    localparam logic [3:0] LIM_S2    = 4'd9;
    localparam logic [3:0] LIM_S1    = 4'd5;
    localparam logic [3:0] LIM_M2    = 4'd9;
    localparam logic [3:0] LIM_M1    = 4'd5;
    localparam logic [3:0] LIM_H2    = 4'd9;
    localparam logic [3:0] LIM_H2_20 = 4'd3;
    localparam logic [3:0] LIM_H1    = 4'd2;

    function automatic logic [3:0] get_digit(input logic [23:0] val, input logic [2:0] idx);
        return val[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [2:0] first_idx(input logic [1:0] mode);
        return (mode == MODE_ALM) ? IDX_M2 : IDX_S2;
    endfunction

    function automatic logic [3:0] digit_limit(input logic [2:0] idx, input logic [3:0] h1);
        case (idx)
            IDX_S2:  return LIM_S2;
            IDX_S1:  return LIM_S1;
            IDX_M2:  return LIM_M2;
            IDX_M1:  return LIM_M1;
            IDX_H2:  return (h1 == 4'd2) ? LIM_H2_20 : LIM_H2;
            default: return LIM_H1;
        endcase
    endfunction

    // Steps one digit with wrap; moving h1 to 2 pulls an out-of-range h2 down to 3.
    function automatic logic [23:0] step_digit(input logic [23:0] val, input logic [2:0] idx,
                                               input logic up);
        logic [23:0] r;
        logic [3:0]  d;
        logic [3:0]  lim;
        logic [3:0]  nd;
        r   = val;
        d   = get_digit(val, idx);
        lim = digit_limit(idx, val[23:20]);
        if (up)
            nd = (d >= lim) ? 4'd0 : d + 4'd1;
        else
            nd = (d == 4'd0) ? lim : d - 4'd1;
        r[{idx, 2'b00} +: 4] = nd;
        if (idx == IDX_H1 && nd == 4'd2 && r[19:16] > LIM_H2_20)
            r[19:16] = LIM_H2_20;
        return r;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registers one push-button and emits a one-cycle rising-edge pulse
module btn_edge (
    input  logic clk_out,
    input  logic swrst,
    input  logic btn,
    output logic pulse
);

    logic cur;
    logic prev;

    always_ff @(posedge clk_out or posedge swrst) begin
        if (swrst) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= btn;
            prev <= cur;
        end
    end

    assign pulse = cur & ~prev;

endmodule

// File: rtl/digit_entry_ctrl.sv
// rtl/digit_entry_ctrl.sv - button-driven BCD time entry with per-digit replay to digi_clk loaders
module digit_entry_ctrl
    import digi_clk_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SEL_W      = 3,
    parameter int DIG_W      = 4
) (
    input  logic                        clk_out,
    input  logic                        swrst,
    input  logic                        btn_enter,
    input  logic                        btn_cancel,
    input  logic                        btn_next,
    input  logic                        btn_inc,
    input  logic                        btn_dec,
    input  logic [1:0]                  mode,
    input  logic [NUM_DIGITS*DIG_W-1:0] cur_digits,
    output logic [SEL_W-1:0]            select,
    output logic [DIG_W-1:0]            loadin,
    output logic                        load,
    output logic                        almin,
    output logic                        tmrin,
    output logic [NUM_DIGITS*DIG_W-1:0] edit_val,
    output logic [SEL_W-1:0]            cursor,
    output logic                        busy,
    output logic                        done
);

    logic enter_p, cancel_p, next_p, inc_p, dec_p;

    btn_edge u_enter  (.clk_out(clk_out), .swrst(swrst), .btn(btn_enter),  .pulse(enter_p));
    btn_edge u_cancel (.clk_out(clk_out), .swrst(swrst), .btn(btn_cancel), .pulse(cancel_p));
    btn_edge u_next   (.clk_out(clk_out), .swrst(swrst), .btn(btn_next),   .pulse(next_p));
    btn_edge u_inc    (.clk_out(clk_out), .swrst(swrst), .btn(btn_inc),    .pulse(inc_p));
    btn_edge u_dec    (.clk_out(clk_out), .swrst(swrst), .btn(btn_dec),    .pulse(dec_p));

    state_t     state;
    logic [1:0] mode_r;
    logic [2:0] cidx;
    logic       hold;
    logic [1:0] mode_eff;

    // Reserved mode 11 behaves as the clock target.
    assign mode_eff = (mode == MODE_ALM || mode == MODE_TMR) ? mode : MODE_CLK;

    always_ff @(posedge clk_out or posedge swrst) begin
        if (swrst) begin
            state    <= ST_IDLE;
            mode_r   <= MODE_CLK;
            cidx     <= 3'd0;
            hold     <= 1'b0;
            select   <= '0;
            loadin   <= '0;
            load     <= 1'b0;
            almin    <= 1'b0;
            tmrin    <= 1'b0;
            edit_val <= '0;
            cursor   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!cancel_p && enter_p) begin
                        edit_val <= cur_digits;
                        mode_r   <= mode_eff;
                        cursor   <= first_idx(mode_eff);
                        busy     <= 1'b1;
                        state    <= ST_EDIT;
                    end
                end
                ST_EDIT: begin
                    if (cancel_p) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (enter_p) begin
                        cidx   <= first_idx(mode_r);
                        hold   <= 1'b0;
                        select <= first_idx(mode_r);
                        loadin <= get_digit(edit_val, first_idx(mode_r));
                        load   <= (mode_r == MODE_CLK);
                        almin  <= (mode_r == MODE_ALM);
                        tmrin  <= (mode_r == MODE_TMR);
                        state  <= ST_COMMIT;
                    end else if (next_p) begin
                        cursor <= (cursor == IDX_H1) ? first_idx(mode_r) : cursor + 3'd1;
                    end else if (inc_p) begin
                        edit_val <= step_digit(edit_val, cursor, 1'b1);
                    end else if (dec_p) begin
                        edit_val <= step_digit(edit_val, cursor, 1'b0);
                    end
                end
                ST_COMMIT: begin
                    // The last digit is presented twice so the consumer can settle its count.
                    if (hold) begin
                        select <= '0;
                        loadin <= '0;
                        load   <= 1'b0;
                        almin  <= 1'b0;
                        tmrin  <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (cidx == IDX_H1) begin
                        hold <= 1'b1;
                    end else begin
                        cidx   <= cidx + 3'd1;
                        select <= cidx + 3'd1;
                        loadin <= get_digit(edit_val, cidx + 3'd1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb/tb_digit_entry_ctrl.sv - directed self-checking bench for digit_entry_ctrl
module tb_digit_entry_ctrl;

    logic        clk_out = 1'b0;
    logic        swrst = 1'b1;
    logic        btn_enter = 1'b0;
    logic        btn_cancel = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [23:0] cur_digits = 24'h0;
    logic [2:0]  select;
    logic [3:0]  loadin;
    logic        load;
    logic        almin;
    logic        tmrin;
    logic [23:0] edit_val;
    logic [2:0]  cursor;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;

    digit_entry_ctrl dut (
        .clk_out(clk_out), .swrst(swrst),
        .btn_enter(btn_enter), .btn_cancel(btn_cancel), .btn_next(btn_next),
        .btn_inc(btn_inc), .btn_dec(btn_dec),
        .mode(mode), .cur_digits(cur_digits),
        .select(select), .loadin(loadin), .load(load), .almin(almin), .tmrin(tmrin),
        .edit_val(edit_val), .cursor(cursor), .busy(busy), .done(done)
    );

    always #5 clk_out = ~clk_out;

    // Button pulse: raise on one falling edge, drop on the next; the action is visible at the third.
    task automatic press(input int which);
        @(negedge clk_out);
        case (which)
            0: btn_enter = 1'b1;
            1: btn_cancel = 1'b1;
            2: btn_next = 1'b1;
            3: btn_inc = 1'b1;
            default: btn_dec = 1'b1;
        endcase
        @(negedge clk_out);
        btn_enter = 1'b0; btn_cancel = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        @(negedge clk_out);
    endtask

    task automatic test_reset;
        @(negedge clk_out);
        n_checks++;
        if ({select, loadin, load, almin, tmrin, edit_val, cursor, busy, done} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {select, loadin, load, almin, tmrin, edit_val, cursor, busy, done});
        end
        swrst = 1'b0;
        repeat (2) @(negedge clk_out);
    endtask

    task automatic test_clock_set;
        logic [3:0] exp_ld [6];
        exp_ld = '{4'd7, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        mode = 2'b00;
        cur_digits = 24'h123456;
        press(0);
        n_checks++;
        if (busy !== 1'b1 || cursor !== 3'd0 || edit_val !== 24'h123456) begin
            n_fail++;
            $display("FAIL clk_enter_edit: busy=%b cursor=%0d val=%h want 1 0 123456", busy, cursor, edit_val);
        end
        press(3);
        n_checks++;
        if (edit_val !== 24'h123457) begin
            n_fail++;
            $display("FAIL clk_inc_s2: got %h want 123457", edit_val);
        end
        press(0);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (select !== 3'((i < 6) ? i : 5) || loadin !== exp_ld[(i < 6) ? i : 5] ||
                load !== 1'b1 || almin !== 1'b0 || tmrin !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL clk_commit_%0d: sel=%0d ld=%0d load=%b alm=%b tmr=%b busy=%b done=%b want sel=%0d ld=%0d load=1",
                         i, select, loadin, load, almin, tmrin, busy, done, (i < 6) ? i : 5, exp_ld[(i < 6) ? i : 5]);
            end
            @(negedge clk_out);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || load !== 1'b0 || select !== 3'd0 || loadin !== 4'd0) begin
            n_fail++;
            $display("FAIL clk_done: done=%b busy=%b load=%b sel=%0d ld=%0d want 1 0 0 0 0", done, busy, load, select, loadin);
        end
        @(negedge clk_out);
        n_checks++;
        if (done !== 1'b0 || edit_val !== 24'h123457) begin
            n_fail++;
            $display("FAIL clk_after_done: done=%b val=%h want 0 123457", done, edit_val);
        end
    endtask

    task automatic test_wrap_clamp;
        mode = 2'b00;
        cur_digits = 24'h190000;
        press(0);
        repeat (5) press(2);
        n_checks++;
        if (cursor !== 3'd5) begin
            n_fail++;
            $display("FAIL wrap_cursor5: got %0d want 5", cursor);
        end
        press(3);
        n_checks++;
        if (edit_val !== 24'h230000) begin
            n_fail++;
            $display("FAIL wrap_h1_clamp: got %h want 230000", edit_val);
        end
        press(3);
        n_checks++;
        if (edit_val !== 24'h030000) begin
            n_fail++;
            $display("FAIL wrap_h1_to0: got %h want 030000", edit_val);
        end
        press(2);
        n_checks++;
        if (cursor !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_cursor0: got %0d want 0", cursor);
        end
        press(4);
        n_checks++;
        if (edit_val !== 24'h030009) begin
            n_fail++;
            $display("FAIL wrap_dec_s2: got %h want 030009", edit_val);
        end
        press(1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_cancel_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_alarm;
        logic [2:0] exp_sel [5];
        logic [3:0] exp_ld [5];
        exp_sel = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
        exp_ld  = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd1};
        mode = 2'b01;
        cur_digits = 24'h123456;
        press(0);
        n_checks++;
        if (cursor !== 3'd2) begin
            n_fail++;
            $display("FAIL alm_cursor: got %0d want 2", cursor);
        end
        mode = 2'b10;
        press(0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (select !== exp_sel[i] || loadin !== exp_ld[i] || almin !== 1'b1 ||
                load !== 1'b0 || tmrin !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL alm_commit_%0d: sel=%0d ld=%0d alm=%b load=%b tmr=%b want sel=%0d ld=%0d alm=1",
                         i, select, loadin, almin, load, tmrin, exp_sel[i], exp_ld[i]);
            end
            @(negedge clk_out);
        end
        n_checks++;
        if (done !== 1'b1 || almin !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL alm_done: done=%b alm=%b busy=%b want 1 0 0", done, almin, busy);
        end
        @(negedge clk_out);
        mode = 2'b00;
    endtask

    task automatic test_cancel_priority;
        int bad;
        bad = 0;
        mode = 2'b00;
        cur_digits = 24'h123456;
        press(0);
        @(negedge clk_out);
        btn_cancel = 1'b1;
        btn_inc = 1'b1;
        @(negedge clk_out);
        btn_cancel = 1'b0;
        btn_inc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_out);
            if (load || almin || tmrin || done || select !== 3'd0 || loadin !== 4'd0) bad++;
        end
        n_checks++;
        if (busy !== 1'b0 || edit_val !== 24'h123456) begin
            n_fail++;
            $display("FAIL cancel_prio: busy=%b val=%h want 0 123456", busy, edit_val);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL cancel_quiet: %0d active cycles, want 0", bad);
        end
    endtask

    task automatic test_held;
        mode = 2'b00;
        cur_digits = 24'h123456;
        press(0);
        @(negedge clk_out);
        btn_inc = 1'b1;
        repeat (10) @(negedge clk_out);
        btn_inc = 1'b0;
        repeat (2) @(negedge clk_out);
        n_checks++;
        if (edit_val !== 24'h123457) begin
            n_fail++;
            $display("FAIL held_inc: got %h want 123457", edit_val);
        end
        press(1);
    endtask

    task automatic test_reset_mid_commit;
        int bad;
        bad = 0;
        mode = 2'b10;
        cur_digits = 24'h123456;
        press(0);
        press(0);
        repeat (2) @(negedge clk_out);
        n_checks++;
        if (tmrin !== 1'b1 || select !== 3'd2 || loadin !== 4'd4 || load !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: tmr=%b sel=%0d ld=%0d load=%b want 1 2 4 0", tmrin, select, loadin, load);
        end
        swrst = 1'b1;
        #1;
        n_checks++;
        if (tmrin !== 1'b0 || select !== 3'd0 || loadin !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: tmr=%b sel=%0d ld=%0d busy=%b want 0", tmrin, select, loadin, busy);
        end
        @(negedge clk_out);
        swrst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_out);
            if (tmrin || load || almin || done || busy || select !== 3'd0 || loadin !== 4'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_no_replay: %0d active cycles, want 0", bad);
        end
        cur_digits = 24'h215900;
        mode = 2'b00;
        press(0);
        n_checks++;
        if (busy !== 1'b1 || edit_val !== 24'h215900 || cursor !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_idle_reenter: busy=%b val=%h cursor=%0d want 1 215900 0", busy, edit_val, cursor);
        end
        press(1);
    endtask

    initial begin
        test_reset;
        test_clock_set;
        test_wrap_clamp;
        test_alarm;
        test_cancel_priority;
        test_held;
        test_reset_mid_commit;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
